regs_ctrl: RTL and testbench



---
 rtl/regs_ctrl_pkg.sv | 28 ++
 rtl/regs_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_regs_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_ctrl_pkg.sv
// regs_ctrl_pkg: shared types and default constants for the host protocol controller
// that sits between the UART byte interfaces and the configuration register bank.
//   state_e  - controller states
//   tx_sel_e - source of the next transmitted byte (register data or acknowledge)
package regs_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrCommit,
        StRdLoad,
        StTxSend,
        StTxWait,
        StTxShift
    } state_e;

    typedef enum logic {
        TxSelData,
        TxSelAck
    } tx_sel_e;

    localparam int unsigned DefNBytes    = 11;
    localparam int unsigned DefTimeoutCyc = 5_000_000;
    localparam logic [7:0]  DefCmdWr     = 8'h57;  // 'W'
    localparam logic [7:0]  DefCmdRd     = 8'h52;  // 'R'
    localparam logic [7:0]  DefAckByte   = 8'h4B;  // 'K'

endpackage

// File: rtl/regs_ctrl.sv
// regs_ctrl: host protocol controller between the UART and the configuration register bank.
// Decodes command bytes, shifts write frames into the bank and commits them (answering with
// an acknowledge byte), loads and serialises read frames, and aborts stalled write frames.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   rx_data, rx_valid  - received byte and its one-cycle strobe
//   tx_busy, txdw      - UART TX busy, current TX byte from the register bank
//   rxdw               - payload byte to the register bank
//   shift_rxregs, load_confregs, load_txregs, shift_txregs - register bank strobes
//   tx_data, tx_start  - byte and one-cycle start request to UART TX
//   busy               - controller not idle
//   cmd_err, timeout_err - one-cycle error pulses
module regs_ctrl
    import regs_ctrl_pkg::*;
#(
    parameter int unsigned N_BYTES     = DefNBytes,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter logic [7:0]  CMD_WR      = DefCmdWr,
    parameter logic [7:0]  CMD_RD      = DefCmdRd,
    parameter logic [7:0]  ACK_BYTE    = DefAckByte
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    input  logic [7:0] txdw,
    output logic [7:0] rxdw,
    output logic       shift_rxregs,
    output logic       load_confregs,
    output logic       load_txregs,
    output logic       shift_txregs,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       cmd_err,
    output logic       timeout_err
);

    localparam int unsigned TimerW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [3:0]  LastIdx  = 4'(N_BYTES - 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    tx_sel_e             tx_sel_q, tx_sel_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                seen_busy_q, seen_busy_d;  // tx_busy rose during TX_WAIT

    logic [7:0] rxdw_q, rxdw_d, tx_data_q, tx_data_d;
    logic shift_rx_q, shift_rx_d, load_conf_q, load_conf_d;
    logic load_tx_q, load_tx_d, shift_tx_q, shift_tx_d;
    logic tx_start_q, tx_start_d, busy_q, busy_d;
    logic cmd_err_q, cmd_err_d, timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        tx_sel_d      = tx_sel_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        seen_busy_d   = seen_busy_q;
        rxdw_d        = rxdw_q;
        tx_data_d     = tx_data_q;
        shift_rx_d    = 1'b0;
        load_conf_d   = 1'b0;
        load_tx_d     = 1'b0;
        shift_tx_d    = 1'b0;
        tx_start_d    = 1'b0;
        cmd_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = StWrData;
                    end else if (rx_data == CMD_RD) begin
                        cnt_d     = '0;
                        // Raised on entry so the bank has loaded before TX_SEND samples txdw.
                        load_tx_d = 1'b1;
                        state_d   = StRdLoad;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StWrData: begin
                if (rx_valid) begin
                    rxdw_d     = rx_data;
                    shift_rx_d = 1'b1;
                    timer_d    = '0;
                    if (cnt_q == LastIdx) begin
                        state_d = StWrCommit;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (timer_q == TimerMax) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWrCommit: begin
                // Last shift_rxregs is high during this cycle; commit follows it.
                load_conf_d = 1'b1;
                tx_sel_d    = TxSelAck;
                state_d     = StTxSend;
            end
            StRdLoad: begin
                tx_sel_d = TxSelData;
                state_d  = StTxSend;
            end
            StTxSend: begin
                if (!tx_busy) begin
                    tx_data_d   = (tx_sel_q == TxSelAck) ? ACK_BYTE : txdw;
                    tx_start_d  = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = StTxWait;
                end
            end
            StTxWait: begin
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if (tx_sel_q == TxSelAck || cnt_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        // Raised on entry so txdw has advanced before the next TX_SEND.
                        shift_tx_d = 1'b1;
                        state_d    = StTxShift;
                    end
                end
            end
            StTxShift: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = StTxSend;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tx_sel_q      <= TxSelData;
            cnt_q         <= '0;
            timer_q       <= '0;
            seen_busy_q   <= 1'b0;
            rxdw_q        <= '0;
            tx_data_q     <= '0;
            shift_rx_q    <= 1'b0;
            load_conf_q   <= 1'b0;
            load_tx_q     <= 1'b0;
            shift_tx_q    <= 1'b0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_sel_q      <= tx_sel_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            seen_busy_q   <= seen_busy_d;
            rxdw_q        <= rxdw_d;
            tx_data_q     <= tx_data_d;
            shift_rx_q    <= shift_rx_d;
            load_conf_q   <= load_conf_d;
            load_tx_q     <= load_tx_d;
            shift_tx_q    <= shift_tx_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            cmd_err_q     <= cmd_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rxdw          = rxdw_q;
    assign shift_rxregs  = shift_rx_q;
    assign load_confregs = load_conf_q;
    assign load_txregs   = load_tx_q;
    assign shift_txregs  = shift_tx_q;
    assign tx_data       = tx_data_q;
    assign tx_start      = tx_start_q;
    assign busy          = busy_q;
    assign cmd_err       = cmd_err_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_regs_ctrl.sv
// tb_regs_ctrl: bench for regs_ctrl with a UART TX responder and a register bank model.
module tb_regs_ctrl;

    localparam int N  = 11;
    localparam int TO = 100;
    localparam logic [7:0] CmdWr = 8'h57;
    localparam logic [7:0] CmdRd = 8'h52;
    localparam logic [7:0] AckB  = 8'h4B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy;
    logic [7:0] txdw;
    logic [7:0] rxdw, tx_data;
    logic shift_rxregs, load_confregs, load_txregs, shift_txregs;
    logic tx_start, busy, cmd_err, timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regs_ctrl #(
        .N_BYTES    (N),
        .TIMEOUT_CYC(TO),
        .CMD_WR     (CmdWr),
        .CMD_RD     (CmdRd),
        .ACK_BYTE   (AckB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_busy      (tx_busy),
        .txdw         (txdw),
        .rxdw         (rxdw),
        .shift_rxregs (shift_rxregs),
        .load_confregs(load_confregs),
        .load_txregs  (load_txregs),
        .shift_txregs (shift_txregs),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .busy         (busy),
        .cmd_err      (cmd_err),
        .timeout_err  (timeout_err)
    );

    // UART TX responder: busy from the cycle after tx_start for u_dur cycles.
    int   u_cnt;
    int   u_dur = 4;
    logic hold_busy = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) u_cnt <= 0;
        else if (tx_start) u_cnt <= u_dur;
        else if (u_cnt != 0) u_cnt <= u_cnt - 1;
    end
    assign tx_busy = (u_cnt != 0) || hold_busy;

    // Register bank: first received byte ends at index 0; txdw is element 0.
    logic [7:0] rx_arr [N];
    logic [7:0] conf_arr [N];
    logic [7:0] tx_arr [N];
    always @(posedge clk) begin
        if (shift_rxregs) begin
            for (int i = 0; i < N - 1; i++) rx_arr[i] <= rx_arr[i+1];
            rx_arr[N-1] <= rxdw;
        end
        if (load_confregs) for (int i = 0; i < N; i++) conf_arr[i] <= rx_arr[i];
        if (load_txregs) begin
            for (int i = 0; i < N; i++) tx_arr[i] <= conf_arr[i];
        end else if (shift_txregs) begin
            for (int i = 0; i < N - 1; i++) tx_arr[i] <= tx_arr[i+1];
            tx_arr[N-1] <= 8'h00;
        end
    end
    assign txdw = tx_arr[0];

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_shift_rx = 0, n_load_conf = 0, n_load_tx = 0, n_shift_tx = 0;
    int n_tx_start = 0, n_cmd_err = 0, n_timeout = 0, n_start_busy = 0;
    int last_rx_cyc = 0, last_shift_cyc = 0, last_load_cyc = 0, timeout_at = 0;
    logic [7:0] rx_log [1024];
    logic [7:0] tx_log [1024];
    always @(negedge clk) begin
        if (rx_valid) last_rx_cyc <= cyc;
        if (shift_rxregs) begin
            rx_log[n_shift_rx % 1024] <= rxdw;
            n_shift_rx <= n_shift_rx + 1;
            last_shift_cyc <= cyc;
        end
        if (load_confregs) begin
            n_load_conf <= n_load_conf + 1;
            last_load_cyc <= cyc;
        end
        if (load_txregs) n_load_tx <= n_load_tx + 1;
        if (shift_txregs) n_shift_tx <= n_shift_tx + 1;
        if (tx_start) begin
            tx_log[n_tx_start % 1024] <= tx_data;
            n_tx_start <= n_tx_start + 1;
            if (tx_busy) n_start_busy <= n_start_busy + 1;
        end
        if (cmd_err) n_cmd_err <= n_cmd_err + 1;
        if (timeout_err) begin
            n_timeout <= n_timeout + 1;
            timeout_at <= cyc;
        end
    end

    // Reference: contents of the last committed write frame.
    logic [7:0] model_conf [N];

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while ((busy || tx_busy) && k < limit);
        checks++;
        if (busy || tx_busy) begin
            failures++;
            $display("FAIL wait_idle: busy=%0b tx_busy=%0b after %0d cycles, required idle",
                     busy, tx_busy, limit);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({rxdw, tx_data, shift_rxregs, load_confregs, load_txregs, shift_txregs, tx_start,
             busy, cmd_err, timeout_err} !== 24'h0) begin
            failures++;
            $display("FAIL reset_outputs: rxdw=%0h tx_data=%0h busy=%0b, required all 0",
                     rxdw, tx_data, busy);
        end
        repeat (2) @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk); #1;
        checks++;
        if ({busy, tx_start, cmd_err, timeout_err} !== 4'h0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%0b tx_start=%0b, required 0", busy, tx_start);
        end
    endtask

    task automatic test_write(input logic [7:0] f [N], input int max_gap);
        int b_rx = n_shift_rx, b_conf = n_load_conf, b_tx = n_tx_start, b_ltx = n_load_tx;
        send_byte(CmdWr, $urandom_range(0, max_gap));
        for (int i = 0; i < N; i++) send_byte(f[i], $urandom_range(0, max_gap));
        wait_idle(2000);
        checks++;
        if (n_shift_rx - b_rx != N) begin
            failures++;
            $display("FAIL wr_shift_count: got %0d, required %0d", n_shift_rx - b_rx, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rx_log[(b_rx + i) % 1024] !== f[i]) begin
                failures++;
                $display("FAIL wr_rxdw[%0d]: got %0h, required %0h", i,
                         rx_log[(b_rx + i) % 1024], f[i]);
            end
        end
        checks++;
        if (n_load_conf - b_conf != 1 || last_load_cyc - last_shift_cyc != 1) begin
            failures++;
            $display("FAIL wr_commit: loads=%0d delay=%0d, required 1 load 1 cycle after shift",
                     n_load_conf - b_conf, last_load_cyc - last_shift_cyc);
        end
        checks++;
        if (n_tx_start - b_tx != 1 || tx_log[b_tx % 1024] !== AckB || n_load_tx != b_ltx) begin
            failures++;
            $display("FAIL wr_ack: starts=%0d byte=%0h load_tx=%0d, required 1 start of %0h",
                     n_tx_start - b_tx, tx_log[b_tx % 1024], n_load_tx - b_ltx, AckB);
        end
        model_conf = f;
    endtask

    task automatic test_read(input bit junk);
        int b_ltx = n_load_tx, b_tx = n_tx_start, b_stx = n_shift_tx;
        int b_rx = n_shift_rx, b_err = n_cmd_err, b_conf = n_load_conf;
        send_byte(CmdRd, 0);
        if (junk) begin
            send_byte(CmdWr, 1);
            for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        end
        wait_idle(3000);
        checks++;
        if (n_load_tx - b_ltx != 1 || n_shift_tx - b_stx != N - 1 || n_tx_start - b_tx != N) begin
            failures++;
            $display("FAIL rd_counts: load_tx=%0d shift_tx=%0d starts=%0d, required 1/%0d/%0d",
                     n_load_tx - b_ltx, n_shift_tx - b_stx, n_tx_start - b_tx, N - 1, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (tx_log[(b_tx + i) % 1024] !== model_conf[i]) begin
                failures++;
                $display("FAIL rd_byte[%0d]: got %0h, required %0h", i,
                         tx_log[(b_tx + i) % 1024], model_conf[i]);
            end
        end
        checks++;
        if (n_shift_rx != b_rx || n_cmd_err != b_err || n_load_conf != b_conf || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_side_effects: shift_rx=%0d cmd_err=%0d load_conf=%0d busy=%0b, required 0",
                     n_shift_rx - b_rx, n_cmd_err - b_err, n_load_conf - b_conf, busy);
        end
    endtask

    task automatic test_timeout();
        int b_to = n_timeout, b_conf = n_load_conf, b_rx = n_shift_rx;
        send_byte(CmdWr, 1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), $urandom_range(0, 3));
        repeat (TO + 20) @(negedge clk);
        #1;
        checks++;
        if (n_timeout - b_to != 1) begin
            failures++;
            $display("FAIL timeout_count: got %0d, required 1", n_timeout - b_to);
        end
        checks++;
        if (timeout_at - last_rx_cyc != TO) begin
            failures++;
            $display("FAIL timeout_latency: got %0d, required %0d", timeout_at - last_rx_cyc, TO);
        end
        checks++;
        if (n_load_conf != b_conf || n_shift_rx - b_rx != 5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: load_conf=%0d shifts=%0d busy=%0b, required 0/5/0",
                     n_load_conf - b_conf, n_shift_rx - b_rx, busy);
        end
    endtask

    task automatic test_cmd_err();
        logic [7:0] bad;
        int b_err = n_cmd_err;
        int b_str = n_shift_rx + n_load_conf + n_load_tx + n_shift_tx + n_tx_start;
        do bad = 8'($urandom); while (bad == CmdWr || bad == CmdRd);
        send_byte(8'h41, 2);
        send_byte(bad, 3);
        #1;
        checks++;
        if (n_cmd_err - b_err != 2) begin
            failures++;
            $display("FAIL cmd_err_count: got %0d, required 2 (bytes 41, %0h)", n_cmd_err - b_err, bad);
        end
        checks++;
        if (n_shift_rx + n_load_conf + n_load_tx + n_shift_tx + n_tx_start != b_str || busy !== 1'b0) begin
            failures++;
            $display("FAIL cmd_err_quiet: strobes=%0d busy=%0b, required 0/0",
                     n_shift_rx + n_load_conf + n_load_tx + n_shift_tx + n_tx_start - b_str, busy);
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] f [N];
        int b_tx = n_tx_start, b_sb = n_start_busy, b_conf = n_load_conf;
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        @(negedge clk); #1;
        hold_busy = 1'b1;
        send_byte(CmdWr, 0);
        for (int i = 0; i < N; i++) send_byte(f[i], 0);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (n_tx_start != b_tx || n_load_conf - b_conf != 1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_no_start: starts=%0d loads=%0d busy=%0b, required 0/1/1",
                     n_tx_start - b_tx, n_load_conf - b_conf, busy);
        end
        hold_busy = 1'b0;
        wait_idle(500);
        checks++;
        if (n_tx_start - b_tx != 1 || tx_log[b_tx % 1024] !== AckB || n_start_busy != b_sb) begin
            failures++;
            $display("FAIL hold_ack: starts=%0d byte=%0h starts_while_busy=%0d, required 1/%0h/0",
                     n_tx_start - b_tx, tx_log[b_tx % 1024], n_start_busy - b_sb, AckB);
        end
        model_conf = f;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] f [N];
        int b_conf = n_load_conf;
        send_byte(CmdWr, 0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), (i == 7) ? 0 : 1);
        // shift_rxregs of the 8th byte is high right now
        rst_n = 1'b0;
        #1;
        checks++;
        if ({shift_rxregs, load_confregs, load_txregs, shift_txregs, tx_start, busy, cmd_err,
             timeout_err, rxdw, tx_data} !== 24'h0) begin
            failures++;
            $display("FAIL midframe_reset_outputs: shift_rx=%0b busy=%0b rxdw=%0h, required all 0",
                     shift_rxregs, busy, rxdw);
        end
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (n_load_conf != b_conf || busy !== 1'b0) begin
            failures++;
            $display("FAIL midframe_no_commit: loads=%0d busy=%0b, required 0/0",
                     n_load_conf - b_conf, busy);
        end
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        test_write(f, 2);
    endtask

    initial begin
        logic [7:0] f [N];
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        for (int i = 0; i < N; i++) f[i] = 8'(i + 1);
        test_write(f, 0);
        test_read(1'b0);
        u_dur = $urandom_range(2, 8);
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        test_write(f, 3);
        u_dur = $urandom_range(2, 8);
        test_read(1'b1);
        test_timeout();
        test_read(1'b0);
        test_cmd_err();
        u_dur = $urandom_range(2, 8);
        test_busy_hold();
        test_read(1'b0);
        test_reset_midframe();
        test_read(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
